// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, write-data select encodings and hazard tag layout.
package core_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    WD_ALU = 2'b00,
    WD_PC4 = 2'b01,
    WD_MEM = 2'b10,
    WD_IMM = 2'b11
  } wd_sel_e;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned TAG_FLAGS  = 3;
  localparam int unsigned TAG_W      = TAG_FLAGS + REG_AW_DEF;

  // Tag layout, MSB first: {valid, we, is_load, rd}
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  is_load;
    logic [REG_AW_DEF-1:0] rd;
  } tag_t;

  function automatic int unsigned tag_width(input int unsigned aw);
    return TAG_FLAGS + aw;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_tag_match.sv
// Compares one ID source operand against every in-flight tag; reports per-stage hits and the youngest hit.
module tag_match
  import core_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned REG_AW = 5
) (
  input  logic                                 i_id_valid,
  input  logic                                 i_use,
  input  logic [REG_AW-1:0]                    i_rs,
  input  logic [STAGES*tag_width(REG_AW)-1:0]  i_tags,
  output logic [STAGES-1:0]                    o_match,
  output logic                                 o_any,
  output logic [2:0]                           o_idx
);

  localparam int unsigned TW = tag_width(REG_AW);

  logic [TW-1:0] w_tag;

  always_comb begin
    o_match = '0;
    o_idx   = '0;
    w_tag   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_tag      = i_tags[k*TW +: TW];
      o_match[k] = i_id_valid & i_use & w_tag[TW-1] & w_tag[TW-2] &
                   (w_tag[REG_AW-1:0] == i_rs) & (i_rs != '0);
    end
    // Walk oldest to youngest so the lowest matching index wins.
    for (int unsigned k = STAGES; k > 0; k--) begin
      if (o_match[k-1]) o_idx = 3'(k-1);
    end
    o_any = |o_match;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard stall/bubble controller with in-flight destination tags.
// Build option HAZARD_FORWARD_EN: load-use-only stalls plus forwarding-mux selects.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_we_i,
  input  logic              id_is_load_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic [2:0]        fwd_rs1_sel_o,
  output logic [2:0]        fwd_rs2_sel_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned TW = tag_width(REG_AW);
`ifdef HAZARD_FORWARD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  logic [STAGES*TW-1:0] r_tags;
  logic [CNT_W-1:0]     r_cnt;
  logic [STAGES-1:0]    w_m1, w_m2;
  logic                 w_any1, w_any2;
  logic [2:0]           w_idx1, w_idx2;
  logic                 w_hazard;
  logic                 w_tag0_load;
  logic [TW-1:0]        w_new_tag;

  tag_match #(.STAGES(STAGES), .REG_AW(REG_AW)) u_match_rs1 (
    .i_id_valid (id_valid_i),
    .i_use      (id_rs1_use_i),
    .i_rs       (id_rs1_i),
    .i_tags     (r_tags),
    .o_match    (w_m1),
    .o_any      (w_any1),
    .o_idx      (w_idx1)
  );

  tag_match #(.STAGES(STAGES), .REG_AW(REG_AW)) u_match_rs2 (
    .i_id_valid (id_valid_i),
    .i_use      (id_rs2_use_i),
    .i_rs       (id_rs2_i),
    .i_tags     (r_tags),
    .o_match    (w_m2),
    .o_any      (w_any2),
    .o_idx      (w_idx2)
  );

  assign w_tag0_load = r_tags[REG_AW];

  always_comb begin
    w_hazard      = FWD_EN ? ((w_m1[0] | w_m2[0]) & w_tag0_load) : (w_any1 | w_any2);
    stall_o       = w_hazard & ~flush_i;
    bubble_o      = stall_o | flush_i;
    fwd_rs1_sel_o = (FWD_EN && w_any1) ? (w_idx1 + 3'd1) : 3'd0;
    fwd_rs2_sel_o = (FWD_EN && w_any2) ? (w_idx2 + 3'd1) : 3'd0;
    w_new_tag     = {id_valid_i & ~bubble_o, id_reg_we_i, id_is_load_i, id_rd_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tags <= '0;
      r_cnt  <= '0;
    end else begin
      for (int unsigned k = STAGES - 1; k > 0; k--) begin
        r_tags[k*TW +: TW] <= r_tags[(k-1)*TW +: TW];
      end
      r_tags[0 +: TW] <= w_new_tag;
      if (stall_o && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (STAGES=3, 3-bit counter so saturation is reachable).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       id_valid_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic       id_rs1_use_i, id_rs2_use_i, id_reg_we_i, id_is_load_i, flush_i;
  logic       stall_o, bubble_o;
  logic [2:0] fwd_rs1_sel_o, fwd_rs2_sel_o;
  logic [2:0] stall_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [2:0]  exp_cnt  = 3'd0;

  typedef struct {
    logic       stall;
    logic       bubble;
    logic       chk_fwd;
    logic [2:0] f1;
    logic [2:0] f2;
    logic [2:0] cnt;
    string      nm;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.STAGES(3), .REG_AW(5), .CNT_W(3)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_use_i  (id_rs1_use_i),
    .id_rs2_use_i  (id_rs2_use_i),
    .id_rd_i       (id_rd_i),
    .id_reg_we_i   (id_reg_we_i),
    .id_is_load_i  (id_is_load_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .bubble_o      (bubble_o),
    .fwd_rs1_sel_o (fwd_rs1_sel_o),
    .fwd_rs2_sel_o (fwd_rs2_sel_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // One ID cycle: drive after the falling edge, push expectations, sample 1ns later.
  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl,
                       input logic es, input logic [2:0] ef1, input logic [2:0] ef2,
                       input string nm);
    exp_t e;
    @(negedge clk);
    id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rs1_use_i = u1; id_rs2_use_i = u2;
    id_rd_i = rd; id_reg_we_i = we; id_is_load_i = ld; flush_i = fl;
    e.stall = es; e.bubble = es | fl; e.chk_fwd = ~es; e.f1 = ef1; e.f2 = ef2;
    e.cnt = exp_cnt; e.nm = nm;
    q.push_back(e);
    #1;
    e = q.pop_front();
    n_checks++;
    if (stall_o !== e.stall) begin
      n_fail++; $display("FAIL %s stall_o: got %b expected %b", e.nm, stall_o, e.stall);
    end
    n_checks++;
    if (bubble_o !== e.bubble) begin
      n_fail++; $display("FAIL %s bubble_o: got %b expected %b", e.nm, bubble_o, e.bubble);
    end
    n_checks++;
    if (stall_cnt_o !== e.cnt) begin
      n_fail++; $display("FAIL %s stall_cnt_o: got %0d expected %0d", e.nm, stall_cnt_o, e.cnt);
    end
    if (e.chk_fwd) begin
      n_checks++;
      if (fwd_rs1_sel_o !== e.f1) begin
        n_fail++; $display("FAIL %s fwd_rs1_sel_o: got %0d expected %0d", e.nm, fwd_rs1_sel_o, e.f1);
      end
      n_checks++;
      if (fwd_rs2_sel_o !== e.f2) begin
        n_fail++; $display("FAIL %s fwd_rs2_sel_o: got %0d expected %0d", e.nm, fwd_rs2_sel_o, e.f2);
      end
    end
    if (es && exp_cnt != 3'd7) exp_cnt = exp_cnt + 3'd1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, "idle");
  endtask

  task automatic test_reset();
    reset_i = 1'b1; id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
    id_rs1_use_i = 1'b0; id_rs2_use_i = 1'b0; id_reg_we_i = 1'b0; id_is_load_i = 1'b0;
    flush_i = 1'b0;
    #12;
    n_checks++;
    if ({stall_o, bubble_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got stall=%b bubble=%b f1=%0d f2=%0d cnt=%0d expected all 0",
               stall_o, bubble_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o);
    end
    reset_i = 1'b0;
    exp_cnt = 3'd0;
  endtask

  task automatic test_raw_back_to_back();
    issue(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, 3'd0, 3'd0, "raw_prod");
`ifdef HAZARD_FORWARD_EN
    issue(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 0, 0, 3'd1, 3'd0, "raw_cons_fwd");
`else
    for (int i = 0; i < 3; i++)
      issue(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 0, 1, 3'd0, 3'd0, "raw_cons_stall");
    issue(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 0, 0, 3'd0, 3'd0, "raw_cons_release");
`endif
    idle(3);
  endtask

  task automatic test_x0();
    issue(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 3'd0, 3'd0, "x0_prod");
    issue(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0, 0, 3'd0, 3'd0, "x0_cons");
    idle(3);
  endtask

  task automatic test_gap_one();
    issue(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 0, 0, 0, 3'd0, 3'd0, "gap_prod");
    issue(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0, 0, 0, 3'd0, 3'd0, "gap_indep");
`ifdef HAZARD_FORWARD_EN
    issue(1, 5'd10, 5'd2, 1, 1, 5'd14, 1, 0, 0, 0, 3'd2, 3'd0, "gap_cons_fwd");
`else
    for (int i = 0; i < 2; i++)
      issue(1, 5'd10, 5'd2, 1, 1, 5'd14, 1, 0, 0, 1, 3'd0, 3'd0, "gap_cons_stall");
    issue(1, 5'd10, 5'd2, 1, 1, 5'd14, 1, 0, 0, 0, 3'd0, 3'd0, "gap_cons_release");
`endif
    idle(3);
  endtask

  task automatic test_load_use();
    issue(1, 5'd1, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0, 3'd0, 3'd0, "lu_load");
`ifdef HAZARD_FORWARD_EN
    issue(1, 5'd4, 5'd4, 1, 1, 5'd8, 1, 0, 0, 1, 3'd0, 3'd0, "lu_cons_stall");
    issue(1, 5'd4, 5'd4, 1, 1, 5'd8, 1, 0, 0, 0, 3'd2, 3'd2, "lu_cons_fwd");
`else
    for (int i = 0; i < 3; i++)
      issue(1, 5'd4, 5'd4, 1, 1, 5'd8, 1, 0, 0, 1, 3'd0, 3'd0, "lu_cons_stall");
    issue(1, 5'd4, 5'd4, 1, 1, 5'd8, 1, 0, 0, 0, 3'd0, 3'd0, "lu_cons_release");
`endif
    idle(3);
  endtask

  task automatic test_youngest_wins();
    issue(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 0, 0, 3'd0, 3'd0, "yw_old");
    issue(1, 5'd3, 5'd2, 1, 1, 5'd9, 1, 0, 0, 0, 3'd0, 3'd0, "yw_young");
`ifdef HAZARD_FORWARD_EN
    issue(1, 5'd9, 5'd0, 1, 1, 5'd15, 1, 0, 0, 0, 3'd1, 3'd0, "yw_cons_fwd");
`else
    for (int i = 0; i < 3; i++)
      issue(1, 5'd9, 5'd0, 1, 1, 5'd15, 1, 0, 0, 1, 3'd0, 3'd0, "yw_cons_stall");
    issue(1, 5'd9, 5'd0, 1, 1, 5'd15, 1, 0, 0, 0, 3'd0, 3'd0, "yw_cons_release");
`endif
    idle(3);
  endtask

  task automatic test_flush();
    logic [2:0] f;
`ifdef HAZARD_FORWARD_EN
    f = 3'd1;
`else
    f = 3'd0;
`endif
    issue(1, 5'd1, 5'd2, 1, 1, 5'd11, 1, 1, 0, 0, 3'd0, 3'd0, "fl_prod");
    issue(1, 5'd11, 5'd0, 1, 0, 5'd12, 1, 0, 1, 0, f, 3'd0, "fl_cons_flushed");
    issue(1, 5'd12, 5'd0, 1, 0, 5'd16, 1, 0, 0, 0, 3'd0, 3'd0, "fl_next_no_tag");
    idle(3);
  endtask

  task automatic test_async_reset();
    issue(1, 5'd1, 5'd2, 1, 1, 5'd20, 1, 1, 0, 0, 3'd0, 3'd0, "ar_prod");
    issue(1, 5'd20, 5'd0, 1, 0, 5'd21, 1, 0, 0, 1, 3'd0, 3'd0, "ar_cons_stall");
    #1 reset_i = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset stall_o: got %b expected 0", stall_o);
    end
    n_checks++;
    if (stall_cnt_o !== 3'd0) begin
      n_fail++; $display("FAIL async_reset stall_cnt_o: got %0d expected 0", stall_cnt_o);
    end
    #1 reset_i = 1'b0;
    exp_cnt = 3'd0;
    issue(1, 5'd20, 5'd0, 1, 0, 5'd21, 1, 0, 0, 0, 3'd0, 3'd0, "ar_after_reset");
    idle(2);
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_raw_back_to_back();
    test_x0();
    test_gap_one();
    test_load_use();
    test_youngest_wins();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
